mult_div: RTL
=============

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; port list follows, clock and reset first.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 src1_i  input  32  operand A (rs); dividend for divide ops.
REQ-005 src2_i  input  32  operand B (rt); divisor for divide ops.
REQ-006 op_i  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 start_i  input  1  start request; sampled only when idle.
REQ-008 hi_we_i  input  1  MTHI: write src1_i into HI; honoured only when idle.
REQ-009 lo_we_i  input  1  MTLO: write src1_i into LO; honoured only when idle.
REQ-010 busy_o  output  1  operation in progress.
REQ-011 done_o  output  1  one-cycle pulse; operation finished.
REQ-012 div_zero_o  output  1  valid with done_o; divisor was zero.
REQ-013 hi_o  output  32  HI register (MFHI source into the ALU operand mux).
REQ-014 lo_o  output  32  LO register (MFLO source into the ALU operand mux).

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN; a 6-bit iteration counter SHALL track progress.
REQ-016 In IDLE, start_i=1 at edge k SHALL latch operands and op, enter RUN, assert busy_o after edge k.
REQ-017 Signed ops SHALL latch operand magnitudes and record the result signs; unsigned ops SHALL latch the operands unchanged.
REQ-018 RUN SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per edge, for 32 steps (edges k+1..k+32).
REQ-019 At edge k+32, HI/LO SHALL be updated, busy_o SHALL drop, and done_o SHALL be high for exactly that one cycle.
REQ-020 MULT/MULTU: {HI,LO} SHALL be the full 64-bit product; for MULT, the 64-bit product SHALL be negated when the operand signs differ.
REQ-021 DIV/DIVU: LO SHALL be the quotient and HI the remainder; for DIV, the quotient SHALL truncate toward zero and the remainder SHALL take the dividend's sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-023 A divide with src2_i=0 SHALL not enter RUN: done_o and div_zero_o SHALL pulse at edge k+1, HI/LO SHALL be unchanged, busy_o SHALL stay 0.
REQ-024 div_zero_o SHALL be 0 whenever done_o is 0 and for all non-zero-divisor completions.
REQ-025 start_i, hi_we_i and lo_we_i while busy_o=1 SHALL be ignored.
REQ-026 In IDLE, if start_i and hi_we_i/lo_we_i are asserted together, start_i SHALL win and the writes SHALL be dropped.
REQ-027 hi_we_i and lo_we_i together in IDLE (without start_i) SHALL write src1_i to both registers.
REQ-028 start_i in the same cycle as done_o (block already back in IDLE) SHALL be accepted, giving back-to-back operation.
REQ-029 hi_o/lo_o SHALL hold their last committed value during RUN; no partial results SHALL be visible.

Reset
REQ-030 rst_i=1 SHALL immediately force IDLE, counter=0, busy_o=0, done_o=0, div_zero_o=0, hi_o=0, lo_o=0.
REQ-031 Reset during RUN SHALL abort the operation with no done_o pulse; the first edge after deassertion SHALL accept a new start_i.

Configuration
REQ-032 Macro MULT_DIV_DIVIDE_EN defined: the divide datapath SHALL be compiled in, and op_i 10/11 SHALL behave per REQ-021..023.
REQ-033 Macro undefined: the divide datapath SHALL be omitted; a start with op_i[1]=1 SHALL pulse done_o at edge k+1 with div_zero_o=0, HI/LO unchanged, busy_o=0.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 32 cycles done_o=1, HI=0xFFFFFFFE, LO=0x00000001, busy_o high for exactly 32 cycles.
REQ-035 MULT 0xFFFFFFFD (-3) x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-036 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-037 DIVU 100 / 0 with HI=0x11, LO=0x22 -> done_o and div_zero_o high at edge k+1, HI/LO still 0x11/0x22.
REQ-038 MULTU 6x7 started; at cycle 10, start_i pulsed with other operands -> ignored, LO=42; repeat with rst_i at cycle 10 -> busy_o, hi_o, lo_o =0 immediately, no done_o.
REQ-039 Idle hi_we_i with src1_i=0x12345678 -> hi_o=0x12345678 next cycle; same write with start_i asserted -> HI set by the operation result only.

Source files
------------

// File: rtl/mult_div.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers (one step per clock, 32 steps).
// Define MULT_DIV_DIVIDE_EN to compile in the restoring divider; otherwise divide ops complete as no-ops.
module mult_div (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [1:0]  op_i,
  input  logic        start_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_p;
  logic [31:0] r_b, r_hi, r_lo;
  logic        r_neg_lo, r_done, r_dz, r_pend, r_pend_dz;
  logic        w_accept, w_short, w_short_dz, w_last;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_madd;
  logic [63:0] w_mstep, w_step;
  logic [31:0] w_res_hi, w_res_lo;

  // Signed ops run on magnitudes; the signs are re-applied on the final step.
  assign w_a_neg = op_i[0] & src1_i[31];
  assign w_b_neg = op_i[0] & src2_i[31];
  assign w_a_mag = w_a_neg ? -src1_i : src1_i;
  assign w_b_mag = w_b_neg ? -src2_i : src2_i;

  // Shift-add: the upper half accumulates, the multiplier drains out of the lower half.
  assign w_madd  = {1'b0, r_p[63:32]} + {1'b0, r_b};
  assign w_mstep = r_p[0] ? {w_madd, r_p[31:1]} : {1'b0, r_p[63:1]};

`ifdef MULT_DIV_DIVIDE_EN
  logic        r_div, r_neg_hi;
  logic [32:0] w_dsub;
  logic [63:0] w_dstep;

  // Restoring divide: r_p holds {remainder, dividend/quotient}.
  assign w_dsub     = r_p[63:31] - {1'b0, r_b};
  assign w_dstep    = w_dsub[32] ? {r_p[62:0], 1'b0} : {w_dsub[31:0], r_p[30:0], 1'b1};
  assign w_short    = op_i[1] && (src2_i == 32'd0);
  assign w_short_dz = w_short;
  assign w_step     = r_div ? w_dstep : w_mstep;

  always_comb begin
    w_res_hi = w_step[63:32];
    w_res_lo = w_step[31:0];
    if (r_div) begin
      if (r_neg_hi) w_res_hi = -w_step[63:32];
      if (r_neg_lo) w_res_lo = -w_step[31:0];
    end else if (r_neg_lo) begin
      {w_res_hi, w_res_lo} = -w_step;
    end
  end
`else
  assign w_short    = op_i[1];
  assign w_short_dz = 1'b0;
  assign w_step     = w_mstep;

  always_comb begin
    {w_res_hi, w_res_lo} = w_step;
    if (r_neg_lo) {w_res_hi, w_res_lo} = -w_step;
  end
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: if (start_i) begin
        w_accept = 1'b1;
        if (!w_short) w_next = RUN;
      end
      RUN: if (r_cnt == 6'd31) begin
        w_last = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= 6'd0;
      r_p       <= 64'd0;
      r_b       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_neg_lo  <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_dz <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      r_div     <= 1'b0;
      r_neg_hi  <= 1'b0;
`endif
    end else begin
      // Short (non-iterating) ops report completion one edge after acceptance.
      r_done <= r_pend | w_last;
      r_dz   <= r_pend & r_pend_dz;
      r_pend <= 1'b0;
      if (w_accept) begin
        if (w_short) begin
          r_pend    <= 1'b1;
          r_pend_dz <= w_short_dz;
        end else begin
          r_cnt    <= 6'd0;
          r_p      <= {32'd0, w_a_mag};
          r_b      <= w_b_mag;
          r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef MULT_DIV_DIVIDE_EN
          r_div    <= op_i[1];
          r_neg_hi <= w_a_neg;
`endif
        end
      end else if (r_state == IDLE) begin
        if (hi_we_i) r_hi <= src1_i;
        if (lo_we_i) r_lo <= src1_i;
      end
      if (r_state == RUN) begin
        r_p   <= w_step;
        r_cnt <= r_cnt + 6'd1;
        if (w_last) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end
    end
  end

  assign busy_o     = (r_state == RUN);
  assign done_o     = r_done;
  assign div_zero_o = r_dz;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule
